// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg
//   Shared constants and helpers for the slide-switch conditioning block.
//   SW_COUNT       : default number of switch bits on the board
//   DEB_1MS_50MHZ  : default debounce window, 1 ms at a 50 MHz clock
//   cnt_width()    : width of the per-bit stability counter for a window
package switch_debounce_pkg;

  localparam int SW_COUNT      = 4;
  localparam int DEB_1MS_50MHZ = 50000;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// debounce_bit
//   One switch bit: synchroniser chain, stability counter, accepted level and
//   registered rise/fall pulses.
//   clk, reset   : system clock, synchronous active-high reset
//   i_raw        : asynchronous raw switch pin
//   o_db         : debounced level
//   o_rise/fall  : one-cycle pulses, aligned with the o_db change
//   o_rise_nxt   : value o_rise takes at the next edge (feeds the top's
//   o_fall_nxt     change flag so it sets in the same cycle as the pulse)
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEB_1MS_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_db;
  logic                   r_rise;
  logic                   r_fall;

  logic w_sync;
  logic w_diff;
  logic w_term;
  logic w_rise_nxt;
  logic w_fall_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Counter only runs while the synchronised level disagrees with the accepted
  // one; the terminal count is the acceptance point, so it never wraps.
  always_comb begin
    w_diff     = w_sync ^ r_db;
    w_term     = w_diff && (r_cnt == CNT_MAX);
    w_rise_nxt = w_term &  w_sync;
    w_fall_nxt = w_term & ~w_sync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      if (!w_diff || w_term) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
      if (w_term) r_db <= w_sync;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign o_db       = r_db;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_rise_nxt = w_rise_nxt;
  assign o_fall_nxt = w_fall_nxt;

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce
//   Conditions raw slide-switch pins: per-bit synchronise + debounce, edge
//   pulses and a sticky change flag for polling or interrupt use.
//   clk, reset  : system clock, synchronous active-high reset
//   sw_raw      : asynchronous raw switch pins
//   sw_db       : debounced switch levels
//   sw_rise     : one-cycle pulse per bit on sw_db 0->1
//   sw_fall     : one-cycle pulse per bit on sw_db 1->0
//   change_irq  : sticky, set by any rise/fall pulse
//   irq_clear   : one-cycle strobe clearing change_irq (a same-cycle event wins)
//   SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NUM_SW          = SW_COUNT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEB_1MS_50MHZ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_db,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              change_irq,
  input  logic              irq_clear
);

  logic [NUM_SW-1:0] w_rise_nxt;
  logic [NUM_SW-1:0] w_fall_nxt;
  logic              w_event;
  logic              r_irq;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .i_raw      (sw_raw[i]),
      .o_db       (sw_db[i]),
      .o_rise     (sw_rise[i]),
      .o_fall     (sw_fall[i]),
      .o_rise_nxt (w_rise_nxt[i]),
      .o_fall_nxt (w_fall_nxt[i])
    );
  end

  // Built from the next-state pulses so the flag rises together with the pulse.
  assign w_event = (|w_rise_nxt) | (|w_fall_nxt);

  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= (r_irq & ~irq_clear) | w_event;
  end

  assign change_irq = r_irq;

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_raw;
  logic [3:0] sw_db;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       change_irq;
  logic       irq_clear;

  switch_debounce #(
    .NUM_SW         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw_db      (sw_db),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .change_irq (change_irq),
    .irq_clear  (irq_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         step;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       irq;
  } chk_t;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  // Expect outputs at (current cycle + d), as seen after that clock edge.
  task automatic want(input int d, input logic [3:0] db, input logic [3:0] rise,
                      input logic [3:0] fall, input logic irq);
    chk_t c;
    c.at = cyc + d; c.step = step;
    c.db = db; c.rise = rise; c.fall = fall; c.irq = irq;
    sb.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard: pop every expectation that is due and compare mid-cycle.
  initial begin
    chk_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        total++;
        assert (e.at == cyc && {sw_db, sw_rise, sw_fall, change_irq} === {e.db, e.rise, e.fall, e.irq})
        else begin
          bad++;
          $error("FAIL step%0d cyc=%0d due=%0d db/rise/fall/irq=%b/%b/%b/%b expected %b/%b/%b/%b",
                 e.step, cyc, e.at, sw_db, sw_rise, sw_fall, change_irq,
                 e.db, e.rise, e.fall, e.irq);
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1; sw_raw = 4'b0000; irq_clear = 1'b0;

    // 1: reset hold, then idle with all-low inputs
    step = 1;
    tick(3);
    for (int d = 0; d < 5; d++) want(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(17);
    reset = 1'b0;
    for (int d = 1; d <= 12; d++) want(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(12);

    // 2: clean rise on bit 0, visible exactly 10 cycles later
    step = 2;
    sw_raw = 4'b0001;
    want(9,  4'b0000, 4'b0000, 4'b0000, 1'b0);
    want(10, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    want(11, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tick(12);

    // 3: bounces of 1, 3 and 7 cycles on bit 1 never get through
    step = 3;
    for (int d = 1; d <= 28; d++) want(d, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    sw_raw = 4'b0011; tick(1);
    sw_raw = 4'b0001; tick(2);
    sw_raw = 4'b0011; tick(3);
    sw_raw = 4'b0001; tick(2);
    sw_raw = 4'b0011; tick(7);
    sw_raw = 4'b0001; tick(13);

    // 4: settle on 0011, then swap to 1100 in one cycle
    step = 4;
    sw_raw = 4'b0011;
    want(10, 4'b0011, 4'b0010, 4'b0000, 1'b1);
    tick(12);
    sw_raw = 4'b1100;
    want(9,  4'b0011, 4'b0000, 4'b0000, 1'b1);
    want(10, 4'b1100, 4'b1100, 4'b0011, 1'b1);
    want(11, 4'b1100, 4'b0000, 4'b0000, 1'b1);
    tick(12);

    // 5: clear coincident with a fall keeps the flag; lone clear drops it
    step = 5;
    sw_raw = 4'b0100;
    want(9,  4'b1100, 4'b0000, 4'b0000, 1'b1);
    want(10, 4'b0100, 4'b0000, 4'b1000, 1'b1);
    want(11, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick(9);
    irq_clear = 1'b1; tick(1);
    irq_clear = 1'b0; tick(3);
    irq_clear = 1'b1;
    want(0, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    for (int d = 1; d <= 5; d++) want(d, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    tick(1); irq_clear = 1'b0;
    tick(2); irq_clear = 1'b1;   // nothing pending: no effect
    tick(1); irq_clear = 1'b0;
    tick(3);

    // 6: reset in the middle of a count on bit 2 discards progress
    step = 6;
    sw_raw = 4'b0000;
    want(10, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    tick(12);
    sw_raw = 4'b0100;
    for (int d = 1; d <= 7; d++)  want(d, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int d = 8; d <= 10; d++) want(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(7);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    for (int d = 1; d <= 9; d++) want(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    want(10, 4'b0100, 4'b0100, 4'b0000, 1'b1);
    want(11, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick(11);

    // drain the scoreboard, bounded
    base = cyc;
    while (sb.size() > 0 && cyc - base < 50) tick(1);
    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL drain pending=%0d expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
